// File: rtl/lsu_mem_port.sv
// Load/store unit driving a byte-addressable data RAM port: one request at a time,
// alignment checking, optional byte-beat splitting, load extension and fault reporting.
module lsu_mem_port #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        rsp_misaligned,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [2:0]  mem_u_b_h_w,
    input  logic [31:0] mem_rdata,
    input  logic        mem_l_fault,
    input  logic        mem_s_fault
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_SPLIT  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic [1:0]  beat_q;
    logic [31:0] asm_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_fault_q;
    logic        rsp_mis_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic        mem_re_q;
    logic [2:0]  mem_size_q;

    logic        req_misaligned_d;
    logic        beat_fault_d;
    logic [1:0]  beat_last_d;
    logic [1:0]  beat_next_d;
    logic [31:0] asm_merged_d;
    logic [7:0]  split_wbyte_d;

    // Word (bit1) takes priority over half (bit0); bit2 selects zero extension.
    function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [2:0] size);
        logic [31:0] res;
        if (size[1]) begin
            res = data;
        end else if (size[0]) begin
            res = size[2] ? {16'h0000, data[15:0]} : {{16{data[15]}}, data[15:0]};
        end else begin
            res = size[2] ? {24'h000000, data[7:0]} : {{24{data[7]}}, data[7:0]};
        end
        return res;
    endfunction

    // Alignment check, beat sequencing and load-byte assembly helpers.
    always_comb begin
        if (req_size[1]) begin
            req_misaligned_d = (req_addr[1:0] != 2'b00);
        end else if (req_size[0]) begin
            req_misaligned_d = req_addr[0];
        end else begin
            req_misaligned_d = 1'b0;
        end
        beat_fault_d  = we_q ? mem_s_fault : mem_l_fault;
        beat_last_d   = size_q[1] ? 2'd3 : 2'd1;
        beat_next_d   = beat_q + 2'd1;
        asm_merged_d  = asm_q;
        asm_merged_d[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
        split_wbyte_d = wdata_q[{beat_next_d, 3'b000} +: 8];
    end

    // Request FSM; memory-port and response outputs are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            size_q      <= 3'b000;
            we_q        <= 1'b0;
            beat_q      <= 2'd0;
            asm_q       <= 32'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_fault_q <= 1'b0;
            rsp_mis_q   <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_size_q  <= 3'b000;
        end else begin
            // The port is idle unless a branch below issues a beat.
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_size_q  <= 3'b000;
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        we_q        <= req_we;
                        beat_q      <= 2'd0;
                        asm_q       <= 32'h0;
                        req_ready_q <= 1'b0;
                        if (!req_misaligned_d) begin
                            state_q     <= ST_ACCESS;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_wdata;
                            mem_size_q  <= req_size;
                            mem_we_q    <= req_we;
                            mem_re_q    <= ~req_we;
                        end else if (SPLIT_MISALIGNED) begin
                            state_q     <= ST_SPLIT;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= {24'h000000, req_wdata[7:0]};
                            mem_size_q  <= 3'b100;
                            mem_we_q    <= req_we;
                            mem_re_q    <= ~req_we;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                            rsp_fault_q <= 1'b0;
                            rsp_mis_q   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_fault_q <= beat_fault_d;
                    rsp_mis_q   <= 1'b0;
                    rsp_rdata_q <= (we_q || beat_fault_d) ? 32'h0 : extend_load(mem_rdata, size_q);
                end
                ST_SPLIT: begin
                    if (beat_fault_d) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b1;
                        rsp_mis_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end else if (beat_q == beat_last_d) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= 1'b0;
                        rsp_mis_q   <= 1'b0;
                        rsp_rdata_q <= we_q ? 32'h0 : extend_load(asm_merged_d, size_q);
                    end else begin
                        beat_q      <= beat_next_d;
                        asm_q       <= asm_merged_d;
                        mem_addr_q  <= addr_q + {30'h0, beat_next_d};
                        mem_wdata_q <= {24'h000000, split_wbyte_d};
                        mem_size_q  <= 3'b100;
                        mem_we_q    <= we_q;
                        mem_re_q    <= ~we_q;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_misaligned = rsp_mis_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_we         = mem_we_q;
    assign mem_re         = mem_re_q;
    assign mem_u_b_h_w    = mem_size_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: expected beats and responses are queued at accept
// and popped when the DUT drives the RAM port or pulses rsp_valid.
module tb_lsu_mem_port;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        mis;
        int          acc;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] mask;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_fault, rsp_misaligned;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_l_fault, mem_s_fault;
    logic [2:0]  mem_u_b_h_w;

    logic        r0_req_valid, r0_req_ready, r0_req_we;
    logic [31:0] r0_req_addr, r0_req_wdata;
    logic [2:0]  r0_req_size;
    logic        r0_rsp_valid, r0_rsp_fault, r0_rsp_misaligned;
    logic [31:0] r0_rsp_rdata;
    logic [31:0] r0_mem_addr, r0_mem_wdata;
    logic        r0_mem_we, r0_mem_re;
    logic [2:0]  r0_mem_u_b_h_w;

    lsu_mem_port #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .rsp_misaligned(rsp_misaligned),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_u_b_h_w(mem_u_b_h_w), .mem_rdata(mem_rdata),
        .mem_l_fault(mem_l_fault), .mem_s_fault(mem_s_fault)
    );

    lsu_mem_port #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_we(r0_req_we),
        .req_addr(r0_req_addr), .req_wdata(r0_req_wdata), .req_size(r0_req_size),
        .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rsp_rdata), .rsp_fault(r0_rsp_fault),
        .rsp_misaligned(r0_rsp_misaligned),
        .mem_addr(r0_mem_addr), .mem_wdata(r0_mem_wdata), .mem_we(r0_mem_we), .mem_re(r0_mem_re),
        .mem_u_b_h_w(r0_mem_u_b_h_w), .mem_rdata(32'h0),
        .mem_l_fault(1'b0), .mem_s_fault(1'b0)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    rsp_t exp_q[$];
    beat_t beat_q[$];
    rsp_t mon_e;
    beat_t mon_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // RAM model: addresses >= 0x80 fault, reads extend by size code, writes on negedge.
    logic [7:0] ram [0:255];
    logic [7:0] base;
    logic [31:0] ram_word;
    logic in_fault;
    always_comb begin
        base      = mem_addr[7:0];
        ram_word  = {ram[base + 8'd3], ram[base + 8'd2], ram[base + 8'd1], ram[base]};
        in_fault  = (mem_addr >= 32'h80);
        mem_l_fault = mem_re & in_fault;
        mem_s_fault = mem_we & in_fault;
        if (in_fault) mem_rdata = 32'h0;
        else if (mem_u_b_h_w[1]) mem_rdata = ram_word;
        else if (mem_u_b_h_w[0]) mem_rdata = mem_u_b_h_w[2] ? {16'h0, ram_word[15:0]} : {{16{ram_word[15]}}, ram_word[15:0]};
        else mem_rdata = mem_u_b_h_w[2] ? {24'h0, ram_word[7:0]} : {{24{ram_word[7]}}, ram_word[7:0]};
    end

    always @(negedge clk) begin
        if (mem_we && !in_fault) begin
            ram[base] <= mem_wdata[7:0];
            if (mem_u_b_h_w[1] || mem_u_b_h_w[0]) ram[base + 8'd1] <= mem_wdata[15:8];
            if (mem_u_b_h_w[1]) begin
                ram[base + 8'd2] <= mem_wdata[23:16];
                ram[base + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor for the splitting instance.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) check_val("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                check_val("rsp_rdata", rsp_rdata, mon_e.rdata);
                check_val("rsp_fault", {31'b0, rsp_fault}, {31'b0, mon_e.fault});
                check_val("rsp_misaligned", {31'b0, rsp_misaligned}, {31'b0, mon_e.mis});
                check_val("rsp_latency", cyc - mon_e.acc + 1, mon_e.lat);
            end
        end
        if (mem_we || mem_re) begin
            if (beat_q.size() == 0) check_val("beat_unexpected", {30'b0, mem_we, mem_re}, 32'd0);
            else begin
                mon_b = beat_q.pop_front();
                check_val("beat_addr", mem_addr, mon_b.addr);
                check_val("beat_we_re", {30'b0, mem_we, mem_re}, {30'b0, mon_b.we, ~mon_b.we});
                check_val("beat_size", {29'b0, mem_u_b_h_w}, {29'b0, mon_b.size});
                check_val("beat_wdata", mem_wdata & mon_b.mask, mon_b.wdata & mon_b.mask);
            end
        end
    end

    // The non-splitting instance must never touch its RAM port in this bench.
    always @(negedge clk) begin
        if (|{r0_mem_we, r0_mem_re, r0_mem_addr, r0_mem_wdata, r0_mem_u_b_h_w})
            check_val("r0_mem_access", {30'b0, r0_mem_we, r0_mem_re}, 32'd0);
    end

    task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, output int acc);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check_val("req_ready_wait", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic push_beats(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] size);
        beat_t b;
        logic mis;
        int n;
        mis = size[1] ? (addr[1:0] != 2'b00) : (size[0] & addr[0]);
        b.we = we;
        if (!mis) begin
            b.addr = addr; b.size = size; b.wdata = wdata; b.mask = 32'hFFFF_FFFF;
            beat_q.push_back(b);
        end else begin
            n = size[1] ? 4 : 2;
            for (int k = 0; k < n; k++) begin
                b.addr = addr + 32'(k); b.size = 3'b100;
                b.wdata = (wdata >> (8 * k)) & 32'hFF; b.mask = 32'h0000_00FF;
                beat_q.push_back(b);
                if (b.addr >= 32'h80) break;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic [31:0] e_rdata,
                          input logic e_fault, input int e_lat);
        int acc;
        rsp_t e;
        accept(we, addr, wdata, size, acc);
        push_beats(we, addr, wdata, size);
        e.rdata = e_rdata; e.fault = e_fault; e.mis = 1'b0; e.acc = acc; e.lat = e_lat;
        exp_q.push_back(e);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("rsp_timeout", exp_q.size(), 32'd0);
        check_val("beats_left", beat_q.size(), 32'd0);
    endtask

    initial begin
        int acc;
        beat_t b;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 3'b000;
        r0_req_valid = 1'b0; r0_req_we = 1'b0; r0_req_addr = 32'h0; r0_req_wdata = 32'h0; r0_req_size = 3'b000;
        repeat (3) @(negedge clk);
        check_val("reset_ready", {31'b0, req_ready}, 32'd1);
        check_val("reset_flags", {24'b0, rsp_valid, rsp_fault, rsp_misaligned, mem_we, mem_re, mem_u_b_h_w}, 32'd0);
        check_val("reset_addr", mem_addr, 32'h0);
        check_val("reset_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 2);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 2);
        do_req(1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFFFFEF, 1'b0, 2);
        do_req(1'b0, 32'h10, 32'h0, 3'b100, 32'h000000EF, 1'b0, 2);
        do_req(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 2);
        do_req(1'b1, 32'h14, 32'h11223344, 3'b010, 32'h0, 1'b0, 2);
        do_req(1'b0, 32'h11, 32'h0, 3'b010, 32'h44DEADBE, 1'b0, 5);
        do_req(1'b0, 32'h11, 32'h0, 3'b001, 32'hFFFFADBE, 1'b0, 3);
        do_req(1'b0, 32'h11, 32'h0, 3'b101, 32'h0000ADBE, 1'b0, 3);
        do_req(1'b1, 32'h15, 32'h0000BEEF, 3'b001, 32'h0, 1'b0, 3);
        do_req(1'b0, 32'h14, 32'h0, 3'b010, 32'h11BEEF44, 1'b0, 2);
        do_req(1'b0, 32'h80, 32'h0, 3'b010, 32'h0, 1'b1, 2);
        do_req(1'b1, 32'h7F, 32'h0000A55A, 3'b001, 32'h0, 1'b1, 3);
        do_req(1'b0, 32'h7F, 32'h0, 3'b100, 32'h0000005A, 1'b0, 2);
        do_req(1'b0, 32'hFFFFFFFE, 32'h0, 3'b010, 32'h0, 1'b1, 2);

        // Reset during beat 1 of a split word store: no response may follow.
        accept(1'b1, 32'h21, 32'hCAFEF00D, 3'b010, acc);
        b.we = 1'b1; b.size = 3'b100; b.mask = 32'h0000_00FF;
        b.addr = 32'h21; b.wdata = 32'h0D; beat_q.push_back(b);
        b.addr = 32'h22; b.wdata = 32'hF0; beat_q.push_back(b);
        @(negedge clk);
        check_val("busy_not_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check_val("split_we_beat1", {31'b0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_async_drop", {30'b0, mem_we, mem_re}, 32'd0);
        check_val("rst_async_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check_val("post_rst_beats", beat_q.size(), 32'd0);

        // Non-splitting instance rejects a misaligned word load in one cycle.
        @(negedge clk);
        r0_req_we = 1'b0; r0_req_addr = 32'h11; r0_req_size = 3'b010; r0_req_wdata = 32'h0;
        r0_req_valid = 1'b1;
        check_val("r0_ready", {31'b0, r0_req_ready}, 32'd1);
        @(posedge clk);
        #1 r0_req_valid = 1'b0;
        @(negedge clk);
        check_val("r0_rsp_valid", {31'b0, r0_rsp_valid}, 32'd1);
        check_val("r0_rsp_misaligned", {31'b0, r0_rsp_misaligned}, 32'd1);
        check_val("r0_rsp_fault", {31'b0, r0_rsp_fault}, 32'd0);
        check_val("r0_rsp_rdata", r0_rsp_rdata, 32'h0);
        @(negedge clk);
        check_val("r0_rsp_pulse", {31'b0, r0_rsp_valid}, 32'd0);
        check_val("r0_ready_back", {31'b0, r0_req_ready}, 32'd1);
        check_val("r0_mis_hold", {31'b0, r0_rsp_misaligned}, 32'd1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
